// File: rtl/mmio_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mmio_ctrl_pkg
// Shared constants for the Riscv151 memory-mapped I/O region: the region base,
// the register offsets within it, and the one-entry buffer state encoding.
// Imported by the core's address decode and by the MMIO controller.
// -----------------------------------------------------------------------------
package mmio_ctrl_pkg;

  localparam logic [31:0] IO_BASE = 32'h8000_0000;

  // Offsets are compared against addr[27:0], so anything not listed here
  // (including misaligned offsets) is an unmapped I/O location.
  localparam logic [27:0] MMIO_UART_CTRL = 28'h000_0000;
  localparam logic [27:0] MMIO_UART_RX   = 28'h000_0004;
  localparam logic [27:0] MMIO_UART_TX   = 28'h000_0008;
  localparam logic [27:0] MMIO_CYCLE_CNT = 28'h000_0010;
  localparam logic [27:0] MMIO_INST_CNT  = 28'h000_0014;
  localparam logic [27:0] MMIO_CNT_RST   = 28'h000_0018;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/mmio_byte_buf.sv
// -----------------------------------------------------------------------------
// mmio_byte_buf
// One-entry, 8-bit valid/ready holding buffer.
//   clk, rst : clock, asynchronous active-high reset
//   push     : offer a byte; accepted only while EMPTY
//   wr_data  : byte captured on an accepted push
//   pop      : release the byte; effective only while FULL
//   full     : buffer holds a byte (valid toward the consumer)
//   data     : held byte (stale after a pop, 0 after reset)
// Push and pop are both judged against the pre-edge state, so a push while
// FULL is dropped even when the pop completes on that same edge.
// -----------------------------------------------------------------------------
module mmio_byte_buf
  import mmio_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic       full,
  output logic [7:0] data
);

  buf_state_e state;
  buf_state_e state_next;
  logic       accept;

  assign full   = (state == BUF_FULL);
  assign accept = push && (state == BUF_EMPTY);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BUF_EMPTY;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      BUF_EMPTY: if (push) state_next = BUF_FULL;
      BUF_FULL:  if (pop)  state_next = BUF_EMPTY;
      default:             state_next = BUF_EMPTY;
    endcase
  end

  // NOTE: the data byte is reset even though it is only meaningful while
  // FULL, because the tx byte is a visible output with a defined reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data <= 8'h00;
    else if (accept) data <= wr_data;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_ctrl
// Memory-mapped I/O controller beside the data memory of the Riscv151 core.
// Decodes I/O-region accesses, buffers one UART rx and one UART tx byte, and
// keeps the cycle and retired-instruction counters. Read data is registered so
// it lines up with synchronous dmem read data in the writeback mux.
//   clk, rst           : clock, asynchronous active-high reset
//   addr, wdata, we, re: data-port access from the execute stage
//   io_sel             : combinational I/O region decode of addr
//   rdata              : registered read data, valid the cycle after re
//   inst_retired       : one pulse per retired instruction
//   uart_rx_*          : receiver -> controller valid/ready byte stream
//   uart_tx_*          : controller -> transmitter valid/ready byte stream
// -----------------------------------------------------------------------------
module mmio_ctrl
  import mmio_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  input  logic        re,
  output logic        io_sel,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  logic [27:0] io_off;
  logic        rd_hit;
  logic        wr_hit;
  logic        rx_pop;
  logic        tx_push;
  logic        cnt_clr;
  logic        rx_full;
  logic        tx_full;
  logic [7:0]  rx_byte;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;
  logic [31:0] rdata_next;
  logic        unused_wdata;

  assign io_sel = (addr[31:28] == IO_BASE[31:28]);
  assign io_off = addr[27:0];
  assign rd_hit = re && io_sel;
  assign wr_hit = (we != 4'b0000) && io_sel;

  assign rx_pop  = rd_hit && (io_off == MMIO_UART_RX);
  assign tx_push = wr_hit && (io_off == MMIO_UART_TX);
  assign cnt_clr = wr_hit && (io_off == MMIO_CNT_RST);

  // Only the low byte of store data reaches the tx buffer.
  assign unused_wdata = ^wdata[31:8];

  mmio_byte_buf u_rx_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (uart_rx_valid),
    .wr_data (uart_rx_data),
    .pop     (rx_pop),
    .full    (rx_full),
    .data    (rx_byte)
  );

  mmio_byte_buf u_tx_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_push),
    .wr_data (wdata[7:0]),
    .pop     (uart_tx_ready),
    .full    (tx_full),
    .data    (uart_tx_data)
  );

  // Both stream outputs come straight from buffer flops, so neither
  // handshake input has a combinational path to an output.
  assign uart_rx_ready = ~rx_full;
  assign uart_tx_valid = tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 32'h0;
      inst_cnt  <= 32'h0;
    end else if (cnt_clr) begin
      cycle_cnt <= 32'h0;
      inst_cnt  <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      inst_cnt  <= inst_cnt + {31'b0, inst_retired};
    end
  end

  // Non-I/O accesses and idle cycles register 0, so rdata only carries data
  // on the cycle after an I/O read.
  always_comb begin
    rdata_next = 32'h0;
    if (rd_hit) begin
      unique case (io_off)
        MMIO_UART_CTRL: rdata_next = {30'b0, rx_full, ~tx_full};
        MMIO_UART_RX:   rdata_next = {24'b0, rx_byte};
        MMIO_CYCLE_CNT: rdata_next = cycle_cnt;
        MMIO_INST_CNT:  rdata_next = inst_cnt;
        default:        rdata_next = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= 32'h0;
    else     rdata <= rdata_next;
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_ctrl
// Directed bench for mmio_ctrl. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point, so every sample reflects the
// state registered by the preceding edge.
// -----------------------------------------------------------------------------
module tb_mmio_ctrl;
  import mmio_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        re;
  logic        io_sel;
  logic [31:0] rdata;
  logic        inst_retired;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  int tests;
  int fails;

  mmio_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .we            (we),
    .re            (re),
    .io_sel        (io_sel),
    .rdata         (rdata),
    .inst_retired  (inst_retired),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    re   = 1'b1;
    tick();
    d    = rdata;
    re   = 1'b0;
    addr = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 4'hF;
    tick();
    we    = 4'h0;
    addr  = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst           = 1'b1;
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h41;
    tick();
    tick();
    tests++;
    if (rdata !== 32'h0 || uart_rx_ready !== 1'b1 || uart_tx_valid !== 1'b0 ||
        uart_tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_values: rdata=%h rx_ready=%b tx_valid=%b tx_data=%h, want 0/1/0/00",
               rdata, uart_rx_ready, uart_tx_valid, uart_tx_data);
    end
    rst = 1'b0;
    tick();
    uart_rx_valid = 1'b0;
    tests++;
    if (uart_rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL rx_capture_ready: got %b want 0", uart_rx_ready);
    end
    rd(IO_BASE + 32'h00, d);
    tests++;
    if (d !== 32'h3) begin
      fails++;
      $display("FAIL ctrl_rx_full: got %h want 00000003", d);
    end
    // Read of rx offset outside the I/O region: 0 and no pop.
    addr = 32'h0000_0004;
    #1;
    tests++;
    if (io_sel !== 1'b0) begin
      fails++;
      $display("FAIL io_sel_low: got %b want 0", io_sel);
    end
    rd(32'h0000_0004, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL non_io_read: got %h want 00000000", d);
    end
    rd(IO_BASE + 32'h04, d);
    tests++;
    if (d !== 32'h41) begin
      fails++;
      $display("FAIL rx_data: got %h want 00000041", d);
    end
    rd(IO_BASE + 32'h00, d);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL ctrl_after_pop: got %h want 00000001", d);
    end
    rd(IO_BASE + 32'h04, d);
    tests++;
    if (d !== 32'h41 || uart_rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL rx_read_empty: got %h ready=%b want 00000041 ready=1", d, uart_rx_ready);
    end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    int          bad;
    uart_tx_ready = 1'b0;
    wr(IO_BASE + 32'h08, 32'hABCD_EF55);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h55) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL tx_hold: %0d bad cycles, want tx_valid=1 data=55", bad);
    end
    wr(IO_BASE + 32'h08, 32'h0000_0066);
    tests++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h55) begin
      fails++;
      $display("FAIL tx_drop_full: valid=%b data=%h want 1/55", uart_tx_valid, uart_tx_data);
    end
    rd(IO_BASE + 32'h00, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL ctrl_tx_full: got %h want 00000000", d);
    end
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    tests++;
    if (uart_tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL tx_handshake: valid=%b want 0", uart_tx_valid);
    end
    rd(IO_BASE + 32'h00, d);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL ctrl_tx_empty: got %h want 00000001", d);
    end
    // Handshake and new write on the same edge: the write is dropped.
    wr(IO_BASE + 32'h08, 32'h11);
    uart_tx_ready = 1'b1;
    wr(IO_BASE + 32'h08, 32'h22);
    uart_tx_ready = 1'b0;
    tests++;
    if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h11) begin
      fails++;
      $display("FAIL tx_same_edge: valid=%b data=%h want 0/11", uart_tx_valid, uart_tx_data);
    end
  endtask

  task automatic test_counters();
    logic [31:0] d;
    logic [9:0]  pat;
    int          since_clr;
    pat = 10'b1101101011;  // seven ones
    inst_retired = 1'b0;
    wr(IO_BASE + 32'h18, 32'h0);
    since_clr = 0;
    for (int i = 0; i < 10; i++) begin
      inst_retired = pat[i];
      tick();
      since_clr++;
    end
    inst_retired = 1'b0;
    rd(IO_BASE + 32'h14, d);
    since_clr++;
    tests++;
    if (d !== 32'd7) begin
      fails++;
      $display("FAIL inst_cnt: got %0d want 7", d);
    end
    rd(IO_BASE + 32'h10, d);
    tests++;
    if (d !== since_clr) begin
      fails++;
      $display("FAIL cycle_cnt: got %0d want %0d", d, since_clr);
    end
    rd(IO_BASE + 32'h0C, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL unmapped_read: got %h want 00000000", d);
    end
    inst_retired = 1'b1;
    wr(IO_BASE + 32'h18, 32'h0);
    inst_retired = 1'b0;
    rd(IO_BASE + 32'h10, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL clr_cycle: got %0d want 0", d);
    end
    inst_retired = 1'b1;
    tick();
    tick();
    wr(IO_BASE + 32'h18, 32'h0);
    inst_retired = 1'b0;
    rd(IO_BASE + 32'h14, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL clr_inst: got %0d want 0", d);
    end
  endtask

  task automatic test_wrap();
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    addr = IO_BASE + 32'h10;
    re   = 1'b1;
    tick();
    tests++;
    if (rdata !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL wrap_max: got %h want ffffffff", rdata);
    end
    tick();
    re   = 1'b0;
    addr = 32'h0;
    tests++;
    if (rdata !== 32'h0) begin
      fails++;
      $display("FAIL wrap_zero: got %h want 00000000", rdata);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d;
    uart_tx_ready = 1'b0;
    wr(IO_BASE + 32'h08, 32'h77);
    tests++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h77) begin
      fails++;
      $display("FAIL tx_load_77: valid=%b data=%h want 1/77", uart_tx_valid, uart_tx_data);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (uart_tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_tx: valid=%b want 0", uart_tx_valid);
    end
    tick();
    rst = 1'b0;
    tick();
    rd(IO_BASE + 32'h00, d);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL ctrl_after_reset: got %h want 00000001", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests         = 0;
    fails         = 0;
    addr          = 32'h0;
    wdata         = 32'h0;
    we            = 4'h0;
    re            = 1'b0;
    inst_retired  = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_tx();
    test_counters();
    test_wrap();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
